alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle command sequencer that owns the 8-bit gate-level ALU.
- Accepts register-to-register commands over a valid/ready handshake and holds a 4×8-bit register file.
- Drives the ALU operand and select inputs from registered state, iterates shift operations for multi-bit shift counts, and captures results and status flags.
- Sits between the command source (test controller or future decoder) and the combinational ALU.

## Interface
Parameters: none. Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept; high only in IDLE
- cmd_op  in  4  opcode: 0 LDI, 1 DEC(B), 2 ADD, 3 SUB, 4 AND, 5 OR, 6 MOV(A), 7 INC(B), 8 SHL(A), 9 SHR(A), 10–15 illegal
- cmd_rd, cmd_ra, cmd_rb  in  2 each  destination and source register indices
- cmd_cnt  in  3  shift count minus one (SHL/SHR only; ignored otherwise)
- cmd_imm  in  8  immediate (LDI only)
- alu_a, alu_b  out  8 each  ALU operands, registered
- alu_c  out  4  ALU operation select, registered
- alu_d  out  2  ALU 4-way flag select; constant 2'b10 (carry)
- alu_e  out  1  ALU 2-way flag select; constant 0
- alu_out  in  8  ALU result
- alu_flags  in  9  ALU flag outputs, in bit order: 0 add, 1 sub, 2 and, 3 or, 4 dec, 5 inc, 6 mov, 7 shl, 8 shr
- done  out  1  one-cycle pulse at command completion
- err  out  1  valid with done; 1 = illegal opcode
- rsp_data  out  8  result of the completed command, held until the next done
- flags  out  3  {C,N,Z} status register
- dbg_addr  in  2 / dbg_data  out  8  combinational register-file read port

## Operation
- States: IDLE, EXEC, WB.
- IDLE: cmd_ready=1.
  - On cmd_valid, latch op/rd/imm/cnt, load opa←R[ra] and opb←R[rb], and set the iteration counter to cnt.
  - Opcodes 0 and 10–15 go directly to WB; all other opcodes go to EXEC.
- EXEC: alu_a=opa, alu_b=opb, alu_c=op, all registered.
  - Each cycle, tmp←alu_out.
  - SHL/SHR: if the counter is nonzero, opa←alu_out, decrement the counter, stay in EXEC; otherwise go to WB.
  - All other ops: one EXEC cycle, then WB.
- WB: done=1.
  - Legal ALU op: R[rd]←tmp, rsp_data←tmp, Z=(tmp==0), N=tmp[7].
  - C: for ADD/SUB/DEC/INC, C←alu_flags bit of that op, sampled in the last EXEC cycle into a one-bit register. For all other legal ops, C←0.
  - LDI: R[rd]←imm, rsp_data←imm, Z/N from imm, C←0.
  - Illegal op: err=1, no register write, flags and rsp_data unchanged.
  - Next state: IDLE.
- DEC and INC use operand B (rb); MOV, SHL and SHR use operand A (ra). The unused operand is still driven, with no effect.
- Source reads happen at accept, so rd equal to ra or rb is safe.
- In IDLE, alu_a, alu_b and alu_c hold their last values. The ALU is combinational and glitching on its inputs is permitted.

## Timing
- Reset values:
  - state IDLE, cmd_ready=1
  - done=0, err=0
  - all R[i]=0x00, rsp_data=0x00, flags=3'b000
  - alu_a=alu_b=0x00, alu_c=4'h0, alu_d=2'b10, alu_e=0
- Reset asserted mid-command aborts it: no done pulse and no write. The command is lost.
- Latency, with accept at edge T:
  - single-pass ALU op: EXEC in cycle T..T+1, done high in cycle T+1..T+2
  - LDI or illegal op: done high in cycle T..T+1
  - SHL/SHR with count k (cnt=k-1): k EXEC cycles, done high k+1 cycles after accept
- Register-file and flag updates are visible on the edge that ends the WB cycle.
- cmd_ready is low from the accept edge until the edge that ends WB, so back-to-back commands accept one cycle after done.
- cmd_valid held high during busy cycles is ignored and not queued. The source must hold the command stable until cmd_ready is seen high.
- cnt=7 gives 8 shift passes, so the result is 0x00.

## Test plan
- LDI R1=0x3C, LDI R2=0xC5, then ADD rd=3, ra=1, rb=2 -> R3=0x01, flags C=1 N=0 Z=0, done two cycles after ADD accept.
- SUB rd=0, ra=1, rb=1 with R1=0x3C -> R0=0x00, Z=1, N=0, C=0.
- SHL rd=2, ra=1, cnt=2 with R1=0x3C -> 3 EXEC cycles, R2=0xE0, N=1; alu_a steps 0x3C, 0x78, 0xF0.
- INC rd=1, rb=2 with R2=0xFF -> R1=0x00, Z=1, C=1. Then op=0xC -> done with err=1; registers, flags and rsp_data unchanged.
- Hold cmd_valid high with 3 commands queued at the source -> each is accepted only while cmd_ready=1; done pulses do not overlap; results are in order.
- Assert rst during the 2nd EXEC cycle of SHR cnt=5 -> no done, every R[i]=0x00, flags=0, cmd_ready=1 on the next cycle after rst deasserts.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle command sequencer: 4x8 register file feeding an external combinational ALU, with iterated shifts.
// Accept-to-done: 1 cycle for LDI or illegal ops, 2 for single-pass ops, k+1 for k-pass shifts; cmd_ready high only in IDLE.
`timescale 1ns/1ps
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_ra,
  input  logic [1:0] cmd_rb,
  input  logic [2:0] cmd_cnt,
  input  logic [7:0] cmd_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_c,
  output logic [1:0] alu_d,
  output logic       alu_e,
  input  logic [7:0] alu_out,
  input  logic [8:0] alu_flags,
  output logic       done,
  output logic       err,
  output logic [7:0] rsp_data,
  output logic [2:0] flags,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  localparam logic [3:0] OP_LDI = 4'd0;
  localparam logic [3:0] OP_DEC = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_INC = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  state_t     state;
  logic [3:0] op_q;
  logic [1:0] rd_q;
  logic [7:0] imm_q;
  logic [2:0] cnt_q;
  logic [7:0] tmp;
  logic       c_q;
  logic [7:0] rf [4];

  logic [3:0] flag_idx;
  logic       carry_sel;
  logic       op_is_shift;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_DEC) && (op <= OP_SHR);
  endfunction

  // The ALU reports a flag per operation; only arithmetic ops carry theirs into C.
  always_comb begin
    flag_idx = 4'd8;
    case (op_q)
      OP_ADD:  flag_idx = 4'd0;
      OP_SUB:  flag_idx = 4'd1;
      OP_AND:  flag_idx = 4'd2;
      OP_OR:   flag_idx = 4'd3;
      OP_DEC:  flag_idx = 4'd4;
      OP_INC:  flag_idx = 4'd5;
      OP_MOV:  flag_idx = 4'd6;
      OP_SHL:  flag_idx = 4'd7;
      default: flag_idx = 4'd8;
    endcase
    carry_sel = 1'b0;
    if (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_DEC || op_q == OP_INC)
      carry_sel = alu_flags[flag_idx];
  end

  assign op_is_shift = (op_q == OP_SHL) || (op_q == OP_SHR);
  assign cmd_ready   = (state == IDLE);
  assign alu_d       = 2'b10;
  assign alu_e       = 1'b0;
  assign dbg_data    = rf[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= 4'h0;
      rd_q     <= 2'd0;
      imm_q    <= 8'h00;
      cnt_q    <= 3'd0;
      tmp      <= 8'h00;
      c_q      <= 1'b0;
      alu_a    <= 8'h00;
      alu_b    <= 8'h00;
      alu_c    <= 4'h0;
      done     <= 1'b0;
      err      <= 1'b0;
      rsp_data <= 8'h00;
      flags    <= 3'b000;
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            imm_q <= cmd_imm;
            cnt_q <= cmd_cnt;
            // Sources are read here, so a destination aliasing a source is harmless.
            if (is_alu_op(cmd_op)) begin
              alu_a <= rf[cmd_ra];
              alu_b <= rf[cmd_rb];
              alu_c <= cmd_op;
              state <= EXEC;
            end else begin
              done  <= 1'b1;
              err   <= (cmd_op != OP_LDI);
              state <= WB;
            end
          end
        end
        EXEC: begin
          tmp <= alu_out;
          c_q <= carry_sel;
          if (op_is_shift && cnt_q != 3'd0) begin
            alu_a <= alu_out;
            cnt_q <= cnt_q - 3'd1;
          end else begin
            done  <= 1'b1;
            err   <= 1'b0;
            state <= WB;
          end
        end
        WB: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
          if (op_q == OP_LDI) begin
            rf[rd_q] <= imm_q;
            rsp_data <= imm_q;
            flags    <= {1'b0, imm_q[7], (imm_q == 8'h00)};
          end else if (is_alu_op(op_q)) begin
            rf[rd_q] <= tmp;
            rsp_data <= tmp;
            flags    <= {c_q, tmp[7], (tmp == 8'h00)};
          end
        end
        default: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU attached to its operand/select outputs.
`timescale 1ns/1ps
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_rd, cmd_ra, cmd_rb;
  logic [2:0] cmd_cnt;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_c;
  logic [1:0] alu_d;
  logic       alu_e;
  logic [7:0] alu_out;
  logic [8:0] alu_flags;
  logic       done, err;
  logic [7:0] rsp_data;
  logic [2:0] flags;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_cnt(cmd_cnt), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_d(alu_d), .alu_e(alu_e),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .done(done), .err(err), .rsp_data(rsp_data), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Combinational ALU: every flag is computed in parallel regardless of alu_c.
  logic [8:0] sum9;
  always_comb begin
    sum9         = {1'b0, alu_a} + {1'b0, alu_b};
    alu_flags    = 9'h000;
    alu_flags[0] = sum9[8];
    alu_flags[1] = (alu_a < alu_b);
    alu_flags[2] = 1'b1;
    alu_flags[3] = 1'b1;
    alu_flags[4] = (alu_b == 8'h00);
    alu_flags[5] = (alu_b == 8'hFF);
    alu_flags[6] = 1'b1;
    alu_flags[7] = alu_a[7];
    alu_flags[8] = alu_a[0];
    case (alu_c)
      4'd1:    alu_out = alu_b - 8'd1;
      4'd2:    alu_out = sum9[7:0];
      4'd3:    alu_out = alu_a - alu_b;
      4'd4:    alu_out = alu_a & alu_b;
      4'd5:    alu_out = alu_a | alu_b;
      4'd6:    alu_out = alu_a;
      4'd7:    alu_out = alu_b + 8'd1;
      4'd8:    alu_out = {alu_a[6:0], 1'b0};
      4'd9:    alu_out = {1'b0, alu_a[7:1]};
      default: alu_out = 8'h00;
    endcase
  end

  typedef struct {
    logic [3:0] op;
    logic [1:0] rd, ra, rb;
    logic [2:0] cnt;
    logic [7:0] imm;
    int         lat;
    logic       e;
    logic [7:0] data;
    logic [2:0] flg;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                      input logic [1:0] rb, input logic [2:0] cnt, input logic [7:0] imm);
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_cnt = cnt; cmd_imm = imm;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic e);
    lat = -1;
    e   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        e   = err;
        return;
      end
    end
  endtask

  task automatic chk_reg(input string name, input logic [1:0] idx, input logic [7:0] exp);
    dbg_addr = idx;
    #1;
    chk(name, dbg_data, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic       e;
    int         ndone, overlap, idx;
    logic       acc;
    logic [7:0] shl_steps [3];
    vec_t       bb [3];

    //          op     rd    ra    rb    cnt   imm    lat e     data   {C,N,Z}
    vt[0]  = '{4'd0,  2'd1, 2'd0, 2'd0, 3'd0, 8'h3C, 1, 1'b0, 8'h3C, 3'b000};
    vt[1]  = '{4'd0,  2'd2, 2'd0, 2'd0, 3'd0, 8'hC5, 1, 1'b0, 8'hC5, 3'b010};
    vt[2]  = '{4'd2,  2'd3, 2'd1, 2'd2, 3'd0, 8'h00, 2, 1'b0, 8'h01, 3'b100};
    vt[3]  = '{4'd3,  2'd0, 2'd1, 2'd1, 3'd0, 8'h00, 2, 1'b0, 8'h00, 3'b001};
    vt[4]  = '{4'd8,  2'd2, 2'd1, 2'd0, 3'd2, 8'h00, 4, 1'b0, 8'hE0, 3'b010};
    vt[5]  = '{4'd0,  2'd2, 2'd0, 2'd0, 3'd0, 8'hFF, 1, 1'b0, 8'hFF, 3'b010};
    vt[6]  = '{4'd7,  2'd1, 2'd0, 2'd2, 3'd0, 8'h00, 2, 1'b0, 8'h00, 3'b101};
    vt[7]  = '{4'hC,  2'd3, 2'd0, 2'd0, 3'd0, 8'h00, 1, 1'b1, 8'h00, 3'b101};
    vt[8]  = '{4'd4,  2'd0, 2'd3, 2'd2, 3'd0, 8'h00, 2, 1'b0, 8'h01, 3'b000};
    vt[9]  = '{4'd5,  2'd3, 2'd2, 2'd0, 3'd0, 8'h00, 2, 1'b0, 8'hFF, 3'b010};
    vt[10] = '{4'd1,  2'd0, 2'd2, 2'd1, 3'd0, 8'h00, 2, 1'b0, 8'hFF, 3'b110};
    vt[11] = '{4'd6,  2'd1, 2'd3, 2'd0, 3'd0, 8'h00, 2, 1'b0, 8'hFF, 3'b010};
    vt[12] = '{4'd9,  2'd2, 2'd3, 2'd0, 3'd0, 8'h00, 2, 1'b0, 8'h7F, 3'b000};
    vt[13] = '{4'd8,  2'd0, 2'd3, 2'd0, 3'd7, 8'h00, 9, 1'b0, 8'h00, 3'b001};
    vt[14] = '{4'd1,  2'd3, 2'd0, 2'd3, 3'd0, 8'h00, 2, 1'b0, 8'hFE, 3'b010};
    vt[15] = '{4'hF,  2'd0, 2'd0, 2'd0, 3'd0, 8'h00, 1, 1'b1, 8'hFE, 3'b010};
    // Register values the illegal-op entries must leave untouched.
    vt[7].imm  = 8'h01;
    vt[15].imm = 8'h00;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_rd = 2'd0; cmd_ra = 2'd0;
    cmd_rb = 2'd0; cmd_cnt = 3'd0; cmd_imm = 8'h00; dbg_addr = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset rsp_data", rsp_data, 8'h00);
    chk("reset flags", flags, 3'b000);
    chk("reset alu_a", alu_a, 8'h00);
    chk("reset alu_b", alu_b, 8'h00);
    chk("reset alu_c", alu_c, 4'h0);
    chk("reset alu_d", alu_d, 2'b10);
    chk("reset alu_e", alu_e, 1'b0);
    for (int r = 0; r < 4; r++) chk_reg($sformatf("reset R%0d", r), 2'(r), 8'h00);

    for (int v = 0; v < 16; v++) begin
      send(vt[v].op, vt[v].rd, vt[v].ra, vt[v].rb, vt[v].cnt, vt[v].imm);
      wait_done(lat, e);
      chk($sformatf("v%0d latency", v), lat, vt[v].lat);
      chk($sformatf("v%0d err", v), e, vt[v].e);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d cmd_ready", v), cmd_ready, 1);
      chk($sformatf("v%0d rsp_data", v), rsp_data, vt[v].data);
      chk($sformatf("v%0d flags", v), flags, vt[v].flg);
      chk_reg($sformatf("v%0d R[rd]", v), vt[v].rd, vt[v].e ? vt[v].imm : vt[v].data);
    end

    // SHL by 3 passes: operand A must step through each intermediate value.
    send(4'd0, 2'd1, 2'd0, 2'd0, 3'd0, 8'h3C);
    wait_done(lat, e);
    shl_steps[0] = 8'h3C; shl_steps[1] = 8'h78; shl_steps[2] = 8'hF0;
    send(4'd8, 2'd2, 2'd1, 2'd0, 3'd2, 8'h00);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("shl step%0d alu_a", s), alu_a, shl_steps[s]);
      chk($sformatf("shl step%0d alu_c", s), alu_c, 4'd8);
      chk($sformatf("shl step%0d done", s), done, 0);
    end
    @(negedge clk);
    chk("shl done pulse", done, 1);
    @(negedge clk);
    chk("shl done one cycle", done, 0);
    chk_reg("shl R2", 2'd2, 8'hE0);

    // Three dependent commands presented with cmd_valid held high throughout.
    bb[0] = '{4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 8'h11, 0, 1'b0, 8'h00, 3'b000};
    bb[1] = '{4'd2, 2'd1, 2'd0, 2'd0, 3'd0, 8'h00, 0, 1'b0, 8'h00, 3'b000};
    bb[2] = '{4'd7, 2'd2, 2'd0, 2'd1, 3'd0, 8'h00, 0, 1'b0, 8'h00, 3'b000};
    ndone = 0; overlap = 0; idx = 0;
    @(negedge clk);
    cmd_op = bb[0].op; cmd_rd = bb[0].rd; cmd_ra = bb[0].ra; cmd_rb = bb[0].rb;
    cmd_cnt = bb[0].cnt; cmd_imm = bb[0].imm; cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && ndone < 3; cyc++) begin
      if (done) begin
        ndone++;
        if (cmd_ready) overlap++;
      end
      acc = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          cmd_op = bb[idx].op; cmd_rd = bb[idx].rd; cmd_ra = bb[idx].ra;
          cmd_rb = bb[idx].rb; cmd_cnt = bb[idx].cnt; cmd_imm = bb[idx].imm;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b done count", ndone, 3);
    chk("b2b accept count", idx, 3);
    chk("b2b done/ready overlap", overlap, 0);
    chk_reg("b2b R0", 2'd0, 8'h11);
    chk_reg("b2b R1", 2'd1, 8'h22);
    chk_reg("b2b R2", 2'd2, 8'h23);
    chk("b2b rsp_data", rsp_data, 8'h23);
    chk("b2b flags", flags, 3'b000);

    // Reset during the second EXEC cycle of a 6-pass SHR aborts the command.
    send(4'd9, 2'd3, 2'd2, 2'd0, 3'd5, 8'h00);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-rst cmd_ready", cmd_ready, 1);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("post-rst no done", ndone, 0);
    chk("post-rst flags", flags, 3'b000);
    chk("post-rst rsp_data", rsp_data, 8'h00);
    chk("post-rst alu_a", alu_a, 8'h00);
    for (int r = 0; r < 4; r++) chk_reg($sformatf("post-rst R%0d", r), 2'(r), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
